// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory request/response,
// decode-side instruction handoff, and execute-side redirect.
// The fetch controller connects through the master modport; the
// memory/decode/execute environment connects through the slave modport.
interface pc_fetch_ctrl_if;
  // instruction memory request channel
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  // instruction memory response channel
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  // decode handoff
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;
  // execute redirect
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] redir_pc;
  logic [25:0] redir_imm;
  logic [31:0] redir_reg;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready,
    input  redir_valid, redir_op, redir_pc, redir_imm, redir_reg
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready,
    output redir_valid, redir_op, redir_pc, redir_imm, redir_reg
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: a four-state FSM that keeps at most one
// instruction-memory read in flight, buffers the returned word for
// decode, and applies execute-stage redirects. A redirect that lands
// while a read is outstanding parks the FSM in DRAIN until that stale
// response comes back, so it can never be mistaken for the new target.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          rst,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] OP_PLUS4  = 2'd0;
  localparam logic [1:0] OP_BRANCH = 2'd1;
  localparam logic [1:0] OP_JUMP   = 2'd2;
  localparam logic [1:0] OP_JR     = 2'd3;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_word;
  logic [31:0] instr_addr;
  logic        req_valid;
  logic        hold_valid;
  logic [31:0] redir_target;

  // Next-PC select for a redirecting instruction. Arithmetic wraps mod 2^32
  // and no alignment is enforced (JR targets are taken as given).
  function automatic logic [31:0] calc_target(
    input logic [1:0]  op,
    input logic [31:0] rpc,
    input logic [25:0] imm,
    input logic [31:0] rreg
  );
    logic [31:0] p4;
    logic [31:0] boff;
    p4   = rpc + 32'd4;
    boff = {{14{imm[15]}}, imm[15:0], 2'b00};
    case (op)
      OP_PLUS4:  calc_target = p4;
      OP_BRANCH: calc_target = p4 + boff;
      OP_JUMP:   calc_target = {p4[31:28], imm, 2'b00};
      OP_JR:     calc_target = rreg;
      default:   calc_target = p4;
    endcase
  endfunction

  // Redirect target decode from the execute-stage fields.
  always_comb begin
    redir_target = 32'd0;
    if (bus.redir_valid) begin
      redir_target = calc_target(bus.redir_op, bus.redir_pc,
                                 bus.redir_imm, bus.redir_reg);
    end else begin
      redir_target = pc;
    end
  end

  // Fetch FSM with registered handshake outputs; redirect always wins
  // over the sequential pc+4 advance, and reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      instr_word <= 32'd0;
      instr_addr <= 32'd0;
      req_valid  <= 1'b1;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.redir_valid) begin
            pc <= redir_target;
            if (bus.imem_req_ready) begin
              // old address already accepted: its response must be drained
              state     <= S_DRAIN;
              req_valid <= 1'b0;
            end else begin
              // request not yet taken, safe to retarget next cycle
              state     <= S_REQ;
              req_valid <= 1'b1;
            end
          end else if (bus.imem_req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
          end else begin
            state     <= S_REQ;
            req_valid <= 1'b1;
          end
          hold_valid <= 1'b0;
        end

        S_WAIT: begin
          if (bus.redir_valid) begin
            pc         <= redir_target;
            hold_valid <= 1'b0;
            if (bus.imem_rsp_valid) begin
              // stale response arrives with the redirect: drop it
              state     <= S_REQ;
              req_valid <= 1'b1;
            end else begin
              state     <= S_DRAIN;
              req_valid <= 1'b0;
            end
          end else if (bus.imem_rsp_valid) begin
            instr_word <= bus.imem_rsp_data;
            instr_addr <= pc;
            state      <= S_HOLD;
            hold_valid <= 1'b1;
            req_valid  <= 1'b0;
          end else begin
            state      <= S_WAIT;
            hold_valid <= 1'b0;
            req_valid  <= 1'b0;
          end
        end

        S_HOLD: begin
          if (bus.redir_valid) begin
            // buffered instruction is on the wrong path; discard it
            pc         <= redir_target;
            state      <= S_REQ;
            hold_valid <= 1'b0;
            req_valid  <= 1'b1;
          end else if (bus.instr_ready) begin
            pc         <= pc + 32'd4;
            state      <= S_REQ;
            hold_valid <= 1'b0;
            req_valid  <= 1'b1;
          end else begin
            state      <= S_HOLD;
            hold_valid <= 1'b1;
            req_valid  <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (bus.redir_valid) begin
            pc <= redir_target;
          end else begin
            pc <= pc;
          end
          if (bus.imem_rsp_valid) begin
            state     <= S_REQ;
            req_valid <= 1'b1;
          end else begin
            state     <= S_DRAIN;
            req_valid <= 1'b0;
          end
          hold_valid <= 1'b0;
        end

        default: begin
          state      <= S_REQ;
          req_valid  <= 1'b1;
          hold_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = hold_valid;
  assign bus.instr_out      = instr_word;
  assign bus.instr_pc       = instr_addr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: linear stimulus, hand-computed
// expectations, immediate assertions at every comparison point.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic redir(input logic [1:0] op, input logic [31:0] rpc,
                       input logic [25:0] imm, input logic [31:0] rreg);
    bus.redir_valid = 1'b1;
    bus.redir_op    = op;
    bus.redir_pc    = rpc;
    bus.redir_imm   = imm;
    bus.redir_reg   = rreg;
  endtask

  task automatic no_redir();
    bus.redir_valid = 1'b0;
    bus.redir_op    = 2'd0;
    bus.redir_pc    = 32'd0;
    bus.redir_imm   = 26'd0;
    bus.redir_reg   = 32'd0;
  endtask

  // From REQ at addr: accept request, return data, end in HOLD.
  task automatic to_hold(input logic [31:0] addr, input logic [31:0] data);
    chk("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("req_addr", bus.imem_req_addr, addr);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("hold_out", bus.instr_out, data);
    chk("hold_pc", bus.instr_pc, addr);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.instr_ready    = 1'b0;
    no_redir();
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0000_3000);
    chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr_out", bus.instr_out, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);

    // zero-wait sequential fetch, 3 cycles per instruction
    to_hold(32'h0000_3000, 32'hA000_0001);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    to_hold(32'h0000_3004, 32'hA000_0002);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    to_hold(32'h0000_3008, 32'hA000_0003);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;

    // HOLD stall for 5 cycles
    to_hold(32'h0000_300C, 32'hB0B0_B0B0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_out", bus.instr_out, 32'hB0B0_B0B0);
      chk("stall_pc", bus.instr_pc, 32'h0000_300C);
      chk("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    chk("after_stall_addr", bus.imem_req_addr, 32'h0000_3010);

    // redirects in REQ without ready: retarget request
    redir(2'd1, 32'h0000_3010, 26'h000_FFFE, 32'd0); tick(); no_redir();
    chk("branch_back_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("branch_back_addr", bus.imem_req_addr, 32'h0000_300C);
    redir(2'd2, 32'h0000_3010, 26'h000_0C40, 32'd0); tick(); no_redir();
    chk("jump_addr", bus.imem_req_addr, 32'h0000_3100);
    redir(2'd0, 32'h0000_3010, 26'h3FF_FFFF, 32'hDEAD_BEEF); tick(); no_redir();
    chk("plus4_addr", bus.imem_req_addr, 32'h0000_3014);

    // redirect with request accepted same cycle -> DRAIN
    bus.imem_req_ready = 1'b1;
    redir(2'd1, 32'h0000_3100, 26'h000_0010, 32'd0); tick(); no_redir();
    bus.imem_req_ready = 1'b0;
    chk("drain_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("drain_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("drain_pc", bus.imem_req_addr, 32'h0000_3144);
    redir(2'd3, 32'd0, 26'd0, 32'h0000_5000); tick(); no_redir();
    chk("drain2_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h5555_5555; tick();
    bus.imem_rsp_valid = 1'b0;
    chk("drained_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("drained_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("drained_addr", bus.imem_req_addr, 32'h0000_5000);

    // JR in WAIT -> DRAIN, stale response suppressed
    bus.imem_req_ready = 1'b1; tick(); bus.imem_req_ready = 1'b0;
    redir(2'd3, 32'd0, 26'd0, 32'h0040_0020); tick(); no_redir();
    chk("jr_wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("jr_wait_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_2222; tick();
    bus.imem_rsp_valid = 1'b0;
    chk("jr_stale_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("jr_addr", bus.imem_req_addr, 32'h0040_0020);
    chk("jr_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);

    // redirect in WAIT with response same cycle -> REQ, misaligned JR kept
    bus.imem_req_ready = 1'b1; tick(); bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h3333_4444;
    redir(2'd3, 32'd0, 26'd0, 32'h0000_0101); tick(); no_redir();
    bus.imem_rsp_valid = 1'b0;
    chk("wait_rsp_redir_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("wait_rsp_redir_req", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("misaligned_addr", bus.imem_req_addr, 32'h0000_0101);

    // redirect and instr_ready together in HOLD
    to_hold(32'h0000_0101, 32'hCAFE_F00D);
    bus.instr_ready = 1'b1;
    redir(2'd2, 32'hF000_0000, 26'h3FF_FFFF, 32'd0); tick(); no_redir();
    bus.instr_ready = 1'b0;
    chk("hold_redir_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("hold_redir_addr", bus.imem_req_addr, 32'hFFFF_FFFC);

    // PLUS4 wraps at 2^32
    redir(2'd0, 32'hFFFF_FFFC, 26'd0, 32'd0); tick(); no_redir();
    chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

    // reset in WAIT beats a redirect; late response ignored afterwards
    bus.imem_req_ready = 1'b1; tick(); bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    redir(2'd3, 32'd0, 26'd0, 32'h0000_7777); tick(); no_redir();
    rst = 1'b0;
    chk("rst_wait_addr", bus.imem_req_addr, 32'h0000_3000);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h9999_9999; tick();
    bus.imem_rsp_valid = 1'b0;
    chk("rst_late_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_late_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rst_late_addr", bus.imem_req_addr, 32'h0000_3000);
    chk("rst_late_out", bus.instr_out, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the fetch address loaded on reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  instruction-memory read request.
REQ-005 imem_req_addr  output  32  request address; equals current PC.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_rsp_valid  input  1  read data returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 instr_valid  output  1  fetched instruction available to decode.
REQ-010 instr_out  output  32  buffered instruction word.
REQ-011 instr_pc  output  32  PC of instr_out.
REQ-012 instr_ready  input  1  decode consumes instr_out this cycle.
REQ-013 redir_valid  input  1  control-flow redirect request from execute.
REQ-014 redir_op  input  2  next-PC select: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR.
REQ-015 redir_pc  input  32  PC of the redirecting instruction.
REQ-016 redir_imm  input  26  immediate field (branch uses [15:0], jump uses [25:0]).
REQ-017 redir_reg  input  32  register target for JR.

Function
REQ-018 States SHALL be REQ, WAIT, HOLD, DRAIN; at most one memory request SHALL be outstanding.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> WAIT.
REQ-020 WAIT: on imem_rsp_valid, capture imem_rsp_data into instr_out and pc into instr_pc -> HOLD; instruction visible the cycle after the response (1-cycle latency).
REQ-021 HOLD: instr_valid=1, instr_out/instr_pc stable; on instr_ready, pc <= pc+4 -> REQ.
REQ-022 instr_valid SHALL be 1 only in HOLD; imem_req_valid SHALL be 1 only in REQ.
REQ-023 Redirect target, with p4 = redir_pc+4 (32-bit, wraps mod 2^32): PLUS4 -> p4; BRANCH -> p4 + {14 copies of redir_imm[15], redir_imm[15:0], 2'b00}; JUMP -> {p4[31:28], redir_imm, 2'b00}; JR -> redir_reg unmodified.
REQ-024 redir_valid SHALL load pc with the target on the same edge, overriding the pc+4 update.
REQ-025 Redirect in HOLD: buffered instruction discarded, even if instr_ready is simultaneous -> REQ.
REQ-026 Redirect in REQ without imem_req_ready -> REQ (new address next cycle); with imem_req_ready same cycle -> DRAIN.
REQ-027 Redirect in WAIT without imem_rsp_valid -> DRAIN; with imem_rsp_valid same cycle -> response discarded, -> REQ.
REQ-028 DRAIN: instr_valid=0, imem_req_valid=0; on imem_rsp_valid discard data -> REQ; a further redirect in DRAIN SHALL update pc and remain in DRAIN.
REQ-029 Redirect in REQ with new target SHALL NOT drop the request handshake: imem_req_addr may change only when the previous request was not accepted.
REQ-030 No alignment checking; JR to misaligned address SHALL be fetched as given.

Reset
REQ-031 On rst=1 at an edge: pc=RESET_PC, state=REQ, instr_out=0, instr_pc=0; rst SHALL override redirect and all handshakes.
REQ-032 Outputs in the cycle after reset: imem_req_valid=1, imem_req_addr=RESET_PC, instr_valid=0.
REQ-033 Reset in WAIT or DRAIN SHALL abandon the outstanding response; a later imem_rsp_valid without a matching request is a memory-model error, not handled.

Verification
REQ-034 Reset, zero-wait memory, instr_ready=1 -> requests at 0x3000, 0x3004, 0x3008; instr_pc follows; one instruction per 3 cycles.
REQ-035 HOLD with instr_ready=0 for 5 cycles -> instr_valid, instr_out, instr_pc stable; no new request.
REQ-036 redir_op=BRANCH, redir_pc=0x3010, imm[15:0]=0xFFFE -> next imem_req_addr=0x300C; redir_op=JUMP, pc=0x3010, imm=0x0000C40 -> 0x00003100.
REQ-037 redir_op=JR, redir_reg=0x0040_0020 in WAIT -> DRAIN; stale response produces no instr_valid; next request 0x0040_0020.
REQ-038 Redirect and instr_ready in the same HOLD cycle -> instruction not consumed-as-advance; next request is redirect target, not pc+4.
REQ-039 rst asserted in WAIT, then response arrives -> ignored; next request at RESET_PC with instr_valid=0.
